// File: rtl/uart_tx_fifo_if.sv
// Byte-queue handshake bundle between the command block, the TX FIFO and the UART transmitter.
// Optional statistics signals are present only when UART_TX_FIFO_STATS_EN is defined.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  tx_busy;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0]           drop_count;
    logic [15:0]           sent_count;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  tx_start, tx_data, fifo_count, full, empty, overflow, drop_count, sent_count
    );
    modport slave (
        input  wr_en, wr_data, tx_busy,
        output tx_start, tx_data, fifo_count, full, empty, overflow, drop_count, sent_count
    );
`else
    modport master (
        output wr_en, wr_data, tx_busy,
        input  tx_start, tx_data, fifo_count, full, empty, overflow
    );
    modport slave (
        input  wr_en, wr_data, tx_busy,
        output tx_start, tx_data, fifo_count, full, empty, overflow
    );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: one start pulse per byte, paced on tx_busy.
// Define UART_TX_FIFO_STATS_EN to add the drop_count / sent_count statistics outputs.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 0
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int TW    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0]       TMO_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic [TW-1:0]           timer;
    logic [GW-1:0]           gap;
    logic                    start_pulse;
    logic [7:0]              data_out;
    logic                    overflow;
    logic                    is_full;
    logic                    is_empty;
    logic                    pop;
    logic                    push;
    logic                    drop;

    assign is_full  = (count == FULL_CNT);
    assign is_empty = (count == '0);
    assign pop      = (state == IDLE) && !is_empty && !bus.tx_busy && (gap == '0);
    // A full FIFO still takes a write when the same edge pops, since a slot frees up.
    assign push     = bus.wr_en && (!is_full || pop);
    assign drop     = bus.wr_en && !push;

    // Storage holds data only; occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            timer       <= '0;
            gap         <= '0;
            start_pulse <= 1'b0;
            data_out    <= 8'd0;
            overflow    <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (gap != '0) begin
                        gap <= gap - 1'b1;
                    end
                    if (pop) begin
                        start_pulse <= 1'b1;
                        data_out    <= mem[rd_ptr];
                        rd_ptr      <= rd_ptr + 1'b1;
                        timer       <= '0;
                        state       <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // A transmitter that never raises busy must not stall the queue forever.
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMO_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        gap   <= GW'(GAP_CYCLES);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start   = start_pulse;
    assign bus.tx_data    = data_out;
    assign bus.fifo_count = count;
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;
    assign bus.overflow   = overflow;

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] drops;
    logic [15:0] sents;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            drops <= 16'd0;
            sents <= 16'd0;
        end else begin
            if (drop) begin
                drops <= sat_inc16(drops);
            end
            if (pop) begin
                sents <= sents + 16'd1;
            end
        end
    end

    assign bus.drop_count = drops;
    assign bus.sent_count = sents;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized traffic against a queue-based model
// and a simple transmitter model that raises busy for a fixed frame length after each start.
module tb_uart_tx_fifo;
    localparam int DL    = 2;
    localparam int DEPTH = 4;
    localparam int T_OUT = 6;
    localparam int GAP   = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    uart_tx_fifo #(
        .DEPTH_LOG2   (DL),
        .START_TIMEOUT(T_OUT),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] q[$];
    logic       exp_ovf;
    logic       pop_s;
    logic       start_bad;
    logic       underflow;
    logic [7:0] exp_byte;
    int         busy_left;
    logic       pending;
    logic       auto_on;
    logic       force_busy;
    int         xmt_len;
    int         pops_m;
    int         drops_m;

    // Transmitter model: busy rises the cycle after the start pulse ends, lasts xmt_len cycles.
    task automatic xmt_step();
        if (busy_left > 0) busy_left--;
        if (pending) begin
            busy_left = xmt_len;
            pending   = 1'b0;
        end
    endtask

    task automatic tick(input logic we, input logic [7:0] wd);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.tx_busy = force_busy || (busy_left > 0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        pop_s     = (bus.tx_start === 1'b1);
        start_bad = pop_s && (bus.tx_busy || pending);
        underflow = 1'b0;
        xmt_step();
        if (pop_s) begin
            pops_m++;
            if (auto_on) pending = 1'b1;
            if (q.size() == 0) underflow = 1'b1;
            else exp_byte = q.pop_front();
        end
        if (we) begin
            if (q.size() < DEPTH) q.push_back(wd);
            else begin
                exp_ovf = 1'b1;
                drops_m++;
            end
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'd0;
        bus.tx_busy = force_busy || (busy_left > 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        xmt_step();
        q.delete();
        exp_ovf = 1'b0;
        pops_m  = 0;
        drops_m = 0;
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
    endtask

    task automatic test_single_byte();
        int extra = 0;
        force_busy = 1'b0; auto_on = 1'b1; xmt_len = 4;
        do_reset();
        tick(1'b1, 8'h11);
        checks++; if (pop_s !== 1'b0) begin errors++; $display("FAIL single_early_start got=%b want=0", pop_s); end
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_wr got=%0d want=1", bus.fifo_count); end
        tick(1'b0, 8'h00);
        checks++; if (pop_s !== 1'b1) begin errors++; $display("FAIL single_start got=%b want=1", pop_s); end
        checks++; if (bus.tx_data !== 8'h11) begin errors++; $display("FAIL single_data got=%h want=11", bus.tx_data); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_pop got=%0d want=0", bus.fifo_count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b want=1", bus.empty); end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00);
            if (pop_s) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL single_extra_starts got=%0d want=0", extra); end
    endtask

    task automatic test_burst();
        logic [7:0] got[$];
        int         pop_cyc[$];
        int         maxc = 0;
        int         bad = 0;
        force_busy = 1'b0; auto_on = 1'b1; xmt_len = 10;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            tick(i < 3, 8'h31 + 8'(i));
            if (pop_s) begin
                got.push_back(bus.tx_data);
                pop_cyc.push_back(cyc);
            end
            if (start_bad || underflow) bad++;
            if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL burst_pops got=%0d want=3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checks++;
            if (got[k] !== 8'h31 + 8'(k)) begin errors++; $display("FAIL burst_order[%0d] got=%h want=%h", k, got[k], 8'h31 + 8'(k)); end
        end
        for (int k = 1; k < pop_cyc.size(); k++) begin
            checks++;
            if (pop_cyc[k] - pop_cyc[k-1] != xmt_len + 3) begin
                errors++; $display("FAIL burst_spacing[%0d] got=%0d want=%0d", k, pop_cyc[k] - pop_cyc[k-1], xmt_len + 3);
            end
        end
        checks++; if (maxc < 2 || maxc > 3) begin errors++; $display("FAIL burst_max_count got=%0d want=2..3", maxc); end
        checks++; if (bad != 0) begin errors++; $display("FAIL burst_start_while_busy got=%0d want=0", bad); end
    endtask

    task automatic test_overflow();
        logic [7:0] b[5];
        logic [7:0] got[$];
        int         early = 0;
        force_busy = 1'b1; auto_on = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            tick(1'b1, b[i]);
            if (pop_s) early++;
            if (i == 2) begin
                checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL ovf_full_at3 got=%b want=0", bus.full); end
            end
            if (i == 3) begin
                checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full_at4 got=%b want=1", bus.full); end
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b want=0", bus.overflow); end
            end
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d want=4", bus.fifo_count); end
        checks++; if (early != 0) begin errors++; $display("FAIL ovf_start_while_busy got=%0d want=0", early); end
        force_busy = 1'b0; auto_on = 1'b1; xmt_len = 2;
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, 8'h00);
            if (pop_s) got.push_back(bus.tx_data);
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL ovf_drain_pops got=%0d want=4", got.size()); end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            checks++;
            if (got[k] !== b[k]) begin errors++; $display("FAIL ovf_drain[%0d] got=%h want=%h", k, got[k], b[k]); end
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
    endtask

    task automatic test_timeout();
        logic [7:0] got[$];
        int         pop_cyc[$];
        force_busy = 1'b0; auto_on = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick(i < 2, (i == 0) ? 8'hAA : 8'hBB);
            if (pop_s) begin
                got.push_back(bus.tx_data);
                pop_cyc.push_back(cyc);
            end
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL tmo_pops got=%0d want=2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== 8'hAA || got[1] !== 8'hBB) begin errors++; $display("FAIL tmo_data got=%h,%h want=aa,bb", got[0], got[1]); end
            checks++; if (pop_cyc[1] - pop_cyc[0] != T_OUT + 1) begin errors++; $display("FAIL tmo_spacing got=%0d want=%0d", pop_cyc[1] - pop_cyc[0], T_OUT + 1); end
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        force_busy = 1'b1; auto_on = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'hC0 + i));
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre_ovf got=%b want=1", bus.overflow); end
        do_reset();
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count got=%0d want=0", bus.fifo_count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got=%b want=0", bus.overflow); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got=%b want=1", bus.empty); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00);
            if (pop_s) stray++;
        end
        force_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00);
            if (pop_s) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rmid_stray_starts got=%0d want=0", stray); end
        tick(1'b1, 8'h5A);
        tick(1'b0, 8'h00);
        checks++; if (pop_s !== 1'b1) begin errors++; $display("FAIL rmid_new_start got=%b want=1", pop_s); end
        checks++; if (bus.tx_data !== 8'h5A) begin errors++; $display("FAIL rmid_new_data got=%h want=5a", bus.tx_data); end
    endtask

    task automatic test_full_pop();
        logic [7:0] b[4];
        logic [7:0] got[$];
        force_busy = 1'b1; auto_on = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            tick(1'b1, b[i]);
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpop_full got=%b want=1", bus.full); end
        force_busy = 1'b0; auto_on = 1'b1; xmt_len = 2;
        tick(1'b1, 8'h55);
        checks++; if (pop_s !== 1'b1) begin errors++; $display("FAIL fpop_start got=%b want=1", pop_s); end
        checks++; if (bus.tx_data !== b[0]) begin errors++; $display("FAIL fpop_data got=%h want=%h", bus.tx_data, b[0]); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpop_ovf got=%b want=0", bus.overflow); end
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fpop_count got=%0d want=4", bus.fifo_count); end
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, 8'h00);
            if (pop_s) got.push_back(bus.tx_data);
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL fpop_drain_pops got=%0d want=4", got.size()); end
        if (got.size() == 4) begin
            checks++;
            if (got[0] !== b[1] || got[1] !== b[2] || got[2] !== b[3] || got[3] !== 8'h55) begin
                errors++; $display("FAIL fpop_order got=%h,%h,%h,%h want=%h,%h,%h,55", got[0], got[1], got[2], got[3], b[1], b[2], b[3]);
            end
        end
    endtask

    task automatic test_random();
        force_busy = 1'b0; auto_on = 1'b1; xmt_len = 3;
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            auto_on = (seg != 1);
            xmt_len = $urandom_range(1, 6);
            for (int i = 0; i < 120; i++) begin
                tick($urandom_range(0, 1) == 1, 8'($urandom));
                checks++; if ({29'd0, bus.fifo_count} !== q.size()) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, bus.fifo_count, q.size()); end
                checks++; if (bus.full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc=%0d got=%b want=%b", cyc, bus.full, q.size() == DEPTH); end
                checks++; if (bus.empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b want=%b", cyc, bus.empty, q.size() == 0); end
                checks++; if (bus.overflow !== exp_ovf) begin errors++; $display("FAIL rnd_overflow cyc=%0d got=%b want=%b", cyc, bus.overflow, exp_ovf); end
                if (pop_s) begin
                    checks++; if (underflow) begin errors++; $display("FAIL rnd_start_on_empty cyc=%0d got=1 want=0", cyc); end
                    checks++; if (!underflow && bus.tx_data !== exp_byte) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, bus.tx_data, exp_byte); end
                    checks++; if (start_bad) begin errors++; $display("FAIL rnd_start_while_busy cyc=%0d got=1 want=0", cyc); end
                end
            end
        end
        auto_on = 1'b1;
        for (int i = 0; i < 300 && (q.size() != 0 || busy_left != 0 || pending); i++) tick(1'b0, 8'h00);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain_model got=%0d want=0", q.size()); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rnd_drain_count got=%0d want=0", bus.fifo_count); end
`ifdef UART_TX_FIFO_STATS_EN
        checks++; if (bus.sent_count !== 16'(pops_m)) begin errors++; $display("FAIL rnd_sent_count got=%0d want=%0d", bus.sent_count, pops_m); end
        checks++; if (bus.drop_count !== 16'(drops_m)) begin errors++; $display("FAIL rnd_drop_count got=%0d want=%0d", bus.drop_count, drops_m); end
`endif
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'd0;
        bus.tx_busy = 1'b0;
        force_busy  = 1'b0;
        auto_on     = 1'b0;
        pending     = 1'b0;
        busy_left   = 0;
        xmt_len     = 1;
        exp_ovf     = 1'b0;
        exp_byte    = 8'd0;
        pops_m      = 0;
        drops_m     = 0;
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_full_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
